alu_rsp_core: RTL and testbench

- Synthesizable ALU responder: the DUT end of the ALU stimulus/monitor interface.
- Accepts ce/mode/cmd/cin/opa/opb with per-operand valid bits (inp_valid) and gathers split operands across cycles with a timeout.
- Executes arithmetic/logical commands, including two-cycle multiplies, and drives registered res/cout/oflow/g/l/e/err back to the bench.

---
 rtl/alu_rsp_core_if.sv | 31 +++
 rtl/alu_rsp_core.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_alu_rsp_core.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/alu_rsp_core_if.sv
// Bench-to-responder ALU bus: command/operand inputs in one direction,
// registered result and flag outputs in the other.
interface alu_rsp_core_if #(
  parameter int OP_WIDTH  = 8,
  parameter int CMD_WIDTH = 4
);
  logic                    ce;
  logic                    mode;
  logic [CMD_WIDTH-1:0]    cmd;
  logic                    cin;
  logic [1:0]              inp_valid;
  logic [OP_WIDTH-1:0]     opa;
  logic [OP_WIDTH-1:0]     opb;
  logic [2*OP_WIDTH-1:0]   res;
  logic                    cout;
  logic                    oflow;
  logic                    g;
  logic                    l;
  logic                    e;
  logic                    err;

  modport master (
    output ce, mode, cmd, cin, inp_valid, opa, opb,
    input  res, cout, oflow, g, l, e, err
  );

  modport slave (
    input  ce, mode, cmd, cin, inp_valid, opa, opb,
    output res, cout, oflow, g, l, e, err
  );
endinterface

// File: rtl/alu_rsp_core.sv
// ALU responder: gathers split operands with a timeout, executes arithmetic and
// logical commands (two-stage multiplies) and returns registered results and flags.
module alu_rsp_core #(
  parameter int OP_WIDTH  = 8,
  parameter int CMD_WIDTH = 4,
  parameter int TIMEOUT   = 16
) (
  input logic           clk,
  input logic           rst,
  alu_rsp_core_if.slave bus
);
  localparam int RW    = 2 * OP_WIDTH;
  localparam int EW    = OP_WIDTH + 1;
  localparam int SH_W  = $clog2(OP_WIDTH);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam int A_ADD = 0, A_SUB = 1, A_ADD_CIN = 2, A_SUB_CIN = 3;
  localparam int A_INC_A = 4, A_DEC_A = 5, A_INC_B = 6, A_DEC_B = 7;
  localparam int A_CMP = 8, A_MUL_INC = 9, A_MUL_SHL = 10;
  localparam int L_AND = 0, L_NAND = 1, L_OR = 2, L_NOR = 3, L_XOR = 4, L_XNOR = 5;
  localparam int L_NOT_A = 6, L_NOT_B = 7, L_SHR1_A = 8, L_SHL1_A = 9;
  localparam int L_SHR1_B = 10, L_SHL1_B = 11, L_ROL = 12, L_ROR = 13;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_EXEC, S_MUL1, S_MUL2} state_t;

  // Returns {valid, needs_a, needs_b} for a command code.
  function automatic logic [2:0] decode_op(input logic m, input logic [CMD_WIDTH-1:0] c);
    logic [2:0] r;
    r = 3'b000;
    if (m) begin
      case (int'(c))
        0, 1, 2, 3, 8, 9, 10: r = 3'b111;
        4, 5:                 r = 3'b110;
        6, 7:                 r = 3'b101;
        default:              r = 3'b000;
      endcase
    end else begin
      case (int'(c))
        0, 1, 2, 3, 4, 5, 12, 13: r = 3'b111;
        6, 8, 9:                  r = 3'b110;
        7, 10, 11:                r = 3'b101;
        default:                  r = 3'b000;
      endcase
    end
    return r;
  endfunction

  function automatic logic is_mul(input logic m, input logic [CMD_WIDTH-1:0] c);
    return m && (int'(c) == A_MUL_INC || int'(c) == A_MUL_SHL);
  endfunction

  state_t               state_q, state_d;
  logic                 mode_q, mode_d, cin_q, cin_d;
  logic [CMD_WIDTH-1:0] cmd_q, cmd_d;
  logic [OP_WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic                 have_a_q, have_a_d, pend_err_q, pend_err_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [EW-1:0]        mul_x_q, mul_x_d, mul_y_q, mul_y_d;
  logic [RW-1:0]        res_q, res_d;
  logic                 cout_q, cout_d, oflow_q, oflow_d;
  logic                 g_q, g_d, l_q, l_d, e_q, e_d, err_q, err_d;

  logic [RW-1:0]        ex_res;
  logic                 ex_cout, ex_oflow, ex_g, ex_l, ex_e, ex_err;
  logic [EW-1:0]        ext_a, ext_b, sum;
  logic [OP_WIDTH-1:0]  dif, lres, shl;
  logic [RW-1:0]        rot, prod;
  logic [2:0]           dec;
  logic                 arrive;

  // Result of the latched single-cycle op; widths kept in temporaries so
  // inversions and shifts happen at operand width before zero-extension.
  always_comb begin
    ex_res   = '0;
    ex_cout  = 1'b0;
    ex_oflow = 1'b0;
    ex_g     = 1'b0;
    ex_l     = 1'b0;
    ex_e     = 1'b0;
    ex_err   = 1'b0;
    ext_a    = EW'(a_q);
    ext_b    = EW'(b_q);
    sum      = '0;
    dif      = '0;
    lres     = '0;
    rot      = '0;
    if (pend_err_q) begin
      ex_err = 1'b1;
    end else if (mode_q) begin
      case (int'(cmd_q))
        A_ADD:     begin sum = ext_a + ext_b;               ex_res = RW'(sum); ex_cout = sum[OP_WIDTH]; end
        A_ADD_CIN: begin sum = ext_a + ext_b + EW'(cin_q);  ex_res = RW'(sum); ex_cout = sum[OP_WIDTH]; end
        A_INC_A:   begin sum = ext_a + EW'(1);              ex_res = RW'(sum); ex_cout = sum[OP_WIDTH]; end
        A_INC_B:   begin sum = ext_b + EW'(1);              ex_res = RW'(sum); ex_cout = sum[OP_WIDTH]; end
        A_SUB:     begin dif = a_q - b_q;                   ex_res = RW'(dif); ex_oflow = (a_q < b_q); end
        A_SUB_CIN: begin
          dif      = a_q - b_q - OP_WIDTH'(cin_q);
          ex_res   = RW'(dif);
          ex_oflow = (ext_a < ext_b + EW'(cin_q));
        end
        A_DEC_A:   begin dif = a_q - OP_WIDTH'(1);          ex_res = RW'(dif); ex_oflow = (a_q == '0); end
        A_DEC_B:   begin dif = b_q - OP_WIDTH'(1);          ex_res = RW'(dif); ex_oflow = (b_q == '0); end
        A_CMP:     begin ex_g = (a_q > b_q); ex_l = (a_q < b_q); ex_e = (a_q == b_q); end
        default:   ex_err = 1'b1;
      endcase
    end else begin
      case (int'(cmd_q))
        L_AND:    lres = a_q & b_q;
        L_NAND:   lres = ~(a_q & b_q);
        L_OR:     lres = a_q | b_q;
        L_NOR:    lres = ~(a_q | b_q);
        L_XOR:    lres = a_q ^ b_q;
        L_XNOR:   lres = ~(a_q ^ b_q);
        L_NOT_A:  lres = ~a_q;
        L_NOT_B:  lres = ~b_q;
        L_SHR1_A: lres = a_q >> 1;
        L_SHL1_A: lres = a_q << 1;
        L_SHR1_B: lres = b_q >> 1;
        L_SHL1_B: lres = b_q << 1;
        L_ROL: begin
          if (|b_q[OP_WIDTH-1:SH_W]) ex_err = 1'b1;
          else begin
            rot  = {a_q, a_q} << b_q[SH_W-1:0];
            lres = rot[RW-1:OP_WIDTH];
          end
        end
        L_ROR: begin
          if (|b_q[OP_WIDTH-1:SH_W]) ex_err = 1'b1;
          else begin
            rot  = {a_q, a_q} >> b_q[SH_W-1:0];
            lres = rot[OP_WIDTH-1:0];
          end
        end
        default: ex_err = 1'b1;
      endcase
      ex_res = RW'(lres);
    end
  end

  // Next-state logic; IDLE and EXEC both accept a new command so single-cycle
  // ops can issue back to back while the previous result is being written.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cmd_d      = cmd_q;
    cin_d      = cin_q;
    a_d        = a_q;
    b_d        = b_q;
    have_a_d   = have_a_q;
    pend_err_d = pend_err_q;
    count_d    = count_q;
    mul_x_d    = mul_x_q;
    mul_y_d    = mul_y_q;
    res_d      = res_q;
    cout_d     = cout_q;
    oflow_d    = oflow_q;
    g_d        = g_q;
    l_d        = l_q;
    e_d        = e_q;
    err_d      = err_q;
    shl        = a_q << 1;
    prod       = RW'(mul_x_q) * RW'(mul_y_q);
    dec        = decode_op(bus.mode, bus.cmd);
    arrive     = have_a_q ? bus.inp_valid[1] : bus.inp_valid[0];

    case (state_q)
      S_WAIT: begin
        count_d = count_q + CNT_W'(1);
        if (arrive) begin
          if (have_a_q) b_d = bus.opb;
          else          a_d = bus.opa;
          state_d = is_mul(mode_q, cmd_q) ? S_MUL1 : S_EXEC;
        end else if (count_q == CNT_W'(TIMEOUT - 1)) begin
          {res_d, cout_d, oflow_d, g_d, l_d, e_d} = '0;
          err_d   = 1'b1;
          count_d = '0;
          state_d = S_IDLE;
        end
      end
      S_MUL1: begin
        if (int'(cmd_q) == A_MUL_INC) begin
          mul_x_d = EW'(a_q) + EW'(1);
          mul_y_d = EW'(b_q) + EW'(1);
        end else begin
          mul_x_d = EW'(shl);
          mul_y_d = EW'(b_q);
        end
        state_d = S_MUL2;
      end
      S_MUL2: begin
        res_d = prod;
        {cout_d, oflow_d, g_d, l_d, e_d, err_d} = '0;
        state_d = S_IDLE;
      end
      S_EXEC: begin
        res_d   = ex_res;
        cout_d  = ex_cout;
        oflow_d = ex_oflow;
        g_d     = ex_g;
        l_d     = ex_l;
        e_d     = ex_e;
        err_d   = ex_err;
        state_d = S_IDLE;
      end
      default: ;
    endcase

    if (state_q == S_IDLE || state_q == S_EXEC) begin
      mode_d     = bus.mode;
      cmd_d      = bus.cmd;
      cin_d      = bus.cin;
      a_d        = bus.opa;
      b_d        = bus.opb;
      have_a_d   = bus.inp_valid[0];
      pend_err_d = 1'b0;
      count_d    = '0;
      if (!dec[2] || bus.inp_valid == 2'b00) begin
        pend_err_d = 1'b1;
        state_d    = S_EXEC;
      end else if (dec[1] && dec[0]) begin
        if (bus.inp_valid == 2'b11) state_d = is_mul(bus.mode, bus.cmd) ? S_MUL1 : S_EXEC;
        else                        state_d = S_WAIT;
      end else begin
        pend_err_d = dec[1] ? !bus.inp_valid[0] : !bus.inp_valid[1];
        state_d    = S_EXEC;
      end
    end
  end

  // ce gates every flop so a deasserted enable freezes the whole responder.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      cmd_q      <= '0;
      cin_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      have_a_q   <= 1'b0;
      pend_err_q <= 1'b0;
      count_q    <= '0;
      mul_x_q    <= '0;
      mul_y_q    <= '0;
      res_q      <= '0;
      cout_q     <= 1'b0;
      oflow_q    <= 1'b0;
      g_q        <= 1'b0;
      l_q        <= 1'b0;
      e_q        <= 1'b0;
      err_q      <= 1'b0;
    end else if (bus.ce) begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cmd_q      <= cmd_d;
      cin_q      <= cin_d;
      a_q        <= a_d;
      b_q        <= b_d;
      have_a_q   <= have_a_d;
      pend_err_q <= pend_err_d;
      count_q    <= count_d;
      mul_x_q    <= mul_x_d;
      mul_y_q    <= mul_y_d;
      res_q      <= res_d;
      cout_q     <= cout_d;
      oflow_q    <= oflow_d;
      g_q        <= g_d;
      l_q        <= l_d;
      e_q        <= e_d;
      err_q      <= err_d;
    end
  end

  assign bus.res   = res_q;
  assign bus.cout  = cout_q;
  assign bus.oflow = oflow_q;
  assign bus.g     = g_q;
  assign bus.l     = l_q;
  assign bus.e     = e_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_alu_rsp_core.sv
// Scoreboard bench for alu_rsp_core: directed vectors push hand-computed
// expectations tagged with the edge they are due on; a monitor checks them.
module tb_alu_rsp_core;
  localparam logic [5:0] F_NONE = 6'b000000;
  localparam logic [5:0] F_COUT = 6'b100000;
  localparam logic [5:0] F_OFL  = 6'b010000;
  localparam logic [5:0] F_L    = 6'b000100;
  localparam logic [5:0] F_E    = 6'b000010;
  localparam logic [5:0] F_ERR  = 6'b000001;

  typedef struct {
    int          due;
    string       name;
    logic [15:0] res;
    logic [5:0]  flags;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  exp_t sb_q[$];

  alu_rsp_core_if #(.OP_WIDTH(8), .CMD_WIDTH(4)) bus ();

  alu_rsp_core #(.OP_WIDTH(8), .CMD_WIDTH(4), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every expectation on the falling edge after its due edge.
  always @(negedge clk) begin
    logic [5:0] act_flags;
    act_flags = {bus.cout, bus.oflow, bus.g, bus.l, bus.e, bus.err};
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      exp_t x;
      x = sb_q.pop_front();
      compared++;
      if (x.due < cyc) begin
        mismatched++;
        $display("[TB] FAIL %s: not sampled on edge %0d (now %0d)", x.name, x.due, cyc);
      end else if (bus.res !== x.res || act_flags !== x.flags) begin
        mismatched++;
        $display("[TB] FAIL %s: got res=%h flags=%b, expected res=%h flags=%b",
                 x.name, bus.res, act_flags, x.res, x.flags);
      end
    end
  end

  task automatic apply_stimulus(input logic ce, input logic mode, input logic [3:0] cmd,
                                input logic cin, input logic [1:0] iv,
                                input logic [7:0] a, input logic [7:0] b);
    bus.ce        = ce;
    bus.mode      = mode;
    bus.cmd       = cmd;
    bus.cin       = cin;
    bus.inp_valid = iv;
    bus.opa       = a;
    bus.opb       = b;
    @(posedge clk);
    #2;
  endtask

  task automatic check_output(input string name, input int lat,
                              input logic [15:0] res, input logic [5:0] flags);
    exp_t x;
    x.due   = cyc + lat;
    x.name  = name;
    x.res   = res;
    x.flags = flags;
    sb_q.push_back(x);
  endtask

  initial begin
    bus.ce = 1'b0; bus.mode = 1'b0; bus.cmd = '0; bus.cin = 1'b0;
    bus.inp_valid = 2'b00; bus.opa = '0; bus.opb = '0;

    apply_stimulus(0, 0, 0, 0, 2'b00, 8'h00, 8'h00);
    apply_stimulus(0, 0, 0, 0, 2'b00, 8'h00, 8'h00);
    check_output("reset", 0, 16'h0000, F_NONE);
    rst = 1'b1;
    apply_stimulus(0, 0, 0, 0, 2'b00, 8'h00, 8'h00);
    check_output("reset_release", 0, 16'h0000, F_NONE);

    apply_stimulus(1, 1, 0, 0, 2'b11, 8'hFF, 8'h01);
    check_output("add_carry", 1, 16'h0100, F_COUT);

    // Split ADD: command changes while waiting must be ignored.
    apply_stimulus(1, 1, 0, 0, 2'b01, 8'h05, 8'h00);
    repeat (3) apply_stimulus(1, 1, 1, 0, 2'b00, 8'h00, 8'h00);
    apply_stimulus(1, 1, 1, 0, 2'b10, 8'h00, 8'h07);
    check_output("split_add_latched", 1, 16'h000C, F_NONE);

    apply_stimulus(1, 1, 8, 0, 2'b11, 8'h05, 8'h09);
    check_output("cmp_lt", 1, 16'h0000, F_L);
    apply_stimulus(1, 1, 8, 0, 2'b11, 8'h09, 8'h09);
    check_output("cmp_eq", 1, 16'h0000, F_E);
    apply_stimulus(1, 1, 1, 0, 2'b11, 8'h03, 8'h05);
    check_output("sub_borrow", 1, 16'h00FE, F_OFL);
    apply_stimulus(1, 0, 12, 0, 2'b11, 8'h81, 8'h01);
    check_output("rol", 1, 16'h0003, F_NONE);
    apply_stimulus(1, 0, 12, 0, 2'b11, 8'h81, 8'h10);
    check_output("rol_bad_amount", 1, 16'h0000, F_ERR);

    apply_stimulus(1, 1, 9, 0, 2'b11, 8'h03, 8'h04);
    check_output("mul_hold", 1, 16'h0000, F_ERR);
    check_output("mul_inc", 2, 16'h0014, F_NONE);
    repeat (2) apply_stimulus(1, 0, 0, 0, 2'b11, 8'hFF, 8'hFF);

    apply_stimulus(1, 1, 10, 0, 2'b11, 8'hC0, 8'h10);
    check_output("mul_shl", 2, 16'h0800, F_NONE);
    repeat (2) apply_stimulus(1, 0, 0, 0, 2'b11, 8'hFF, 8'hFF);

    // Reset while a multiply is in flight discards it.
    apply_stimulus(1, 1, 9, 0, 2'b11, 8'h03, 8'h04);
    rst = 1'b0;
    apply_stimulus(0, 0, 0, 0, 2'b00, 8'h00, 8'h00);
    check_output("reset_mid_mul", 0, 16'h0000, F_NONE);
    apply_stimulus(1, 0, 0, 0, 2'b00, 8'h00, 8'h00);
    check_output("reset_hold", 0, 16'h0000, F_NONE);
    rst = 1'b1;
    apply_stimulus(0, 0, 0, 0, 2'b00, 8'h00, 8'h00);
    check_output("no_mul_result", 0, 16'h0000, F_NONE);

    apply_stimulus(1, 1, 9, 0, 2'b01, 8'h03, 8'h00);
    repeat (15) apply_stimulus(1, 1, 9, 0, 2'b00, 8'h00, 8'h00);
    check_output("timeout_pending", 0, 16'h0000, F_NONE);
    apply_stimulus(1, 1, 9, 0, 2'b00, 8'h00, 8'h00);
    check_output("timeout", 0, 16'h0000, F_ERR);

    apply_stimulus(1, 1, 2, 1, 2'b11, 8'h80, 8'h7F);
    check_output("add_cin", 1, 16'h0100, F_COUT);
    apply_stimulus(1, 1, 3, 1, 2'b11, 8'h05, 8'h05);
    check_output("sub_cin_borrow", 1, 16'h00FF, F_OFL);
    apply_stimulus(1, 1, 5, 0, 2'b01, 8'h00, 8'h00);
    check_output("dec_a_underflow", 1, 16'h00FF, F_OFL);
    apply_stimulus(1, 1, 6, 0, 2'b10, 8'h00, 8'hFF);
    check_output("inc_b_carry", 1, 16'h0100, F_COUT);
    apply_stimulus(1, 1, 4, 0, 2'b10, 8'h00, 8'h00);
    check_output("inc_a_missing_a", 1, 16'h0000, F_ERR);
    apply_stimulus(1, 0, 11, 0, 2'b10, 8'h00, 8'h81);
    check_output("shl1_b", 1, 16'h0002, F_NONE);
    apply_stimulus(1, 1, 11, 0, 2'b11, 8'h00, 8'h00);
    check_output("invalid_cmd", 1, 16'h0000, F_ERR);
    apply_stimulus(1, 0, 5, 0, 2'b11, 8'hF0, 8'hAA);
    check_output("xnor", 1, 16'h00A5, F_NONE);

    // Freeze mid-wait: counter must resume from 2, so arrival lands on count 15.
    apply_stimulus(1, 1, 0, 0, 2'b01, 8'h10, 8'h00);
    repeat (2) apply_stimulus(1, 1, 0, 0, 2'b00, 8'h00, 8'h00);
    repeat (4) begin
      apply_stimulus(0, 1, 0, 0, 2'b10, 8'h00, 8'h20);
      check_output("ce_freeze", 0, 16'h00A5, F_NONE);
    end
    repeat (13) apply_stimulus(1, 1, 0, 0, 2'b00, 8'h00, 8'h00);
    check_output("wait_resumed", 0, 16'h00A5, F_NONE);
    apply_stimulus(1, 1, 0, 0, 2'b10, 8'h00, 8'h20);
    check_output("arrival_beats_timeout", 1, 16'h0030, F_NONE);

    apply_stimulus(1, 0, 6, 0, 2'b01, 8'h0F, 8'h00);
    check_output("not_a", 1, 16'h00F0, F_NONE);
    apply_stimulus(1, 0, 0, 0, 2'b11, 8'h3C, 8'h0F);
    apply_stimulus(0, 0, 0, 0, 2'b00, 8'h00, 8'h00);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    while (sb_q.size() > 0) begin
      exp_t x;
      x = sb_q.pop_front();
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: never checked, expected res=%h flags=%b", x.name, x.res, x.flags);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
